// File: rtl/pret_pkg.sv
// Shared types and helpers for the PRET stream engine: FSM states, bit reversal,
// trailing-zero count and the derived width calculations.
package pret_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  function automatic int calc_tw(input int w, input int n, input int nc, input int corr);
    return (corr != 0) ? (w + nc) : (w * n + nc);
  endfunction

  function automatic int calc_ew(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int calc_lw(input int tw);
    return tw + 1;
  endfunction

  // Reverses the low 'width' bits of value; width 0 yields 0.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] rev;
    for (int i = 0; i < 32; i++) begin
      rev[31 - i] = value[i];
    end
    return (width <= 0) ? 32'd0 : (rev >> (32 - width));
  endfunction

  function automatic int trailing_zeros(input logic [31:0] value, input int width);
    int tz;
    tz = width;
    for (int i = 31; i >= 0; i--) begin
      if ((i < width) && value[i]) begin
        tz = i;
      end
    end
    return tz;
  endfunction

endpackage

// File: rtl/pret_stream_prec.sv
// Combinational precision finder: per-group required precision, disjoint slice
// offsets and the total stream exponent E for the job currently offered.
module pret_prec import pret_pkg::*; #(
  parameter int W    = 8,
  parameter int N    = 2,
  parameter int NC   = 1,
  parameter int CORR = 1,
  parameter int EW   = calc_ew(W),
  parameter int PW   = calc_ew(calc_tw(W, N, NC, CORR))
) (
  input  logic [N*W-1:0]  Bxs,
  input  logic [EW-1:0]   prec_cap,
  output logic [N*EW-1:0] ell,
  output logic [N*PW-1:0] offs,
  output logic [PW-1:0]   e
);

  // Precision per group, running slice offset and total exponent.
  always_comb begin
    logic [W-1:0] grp;
    logic [W-1:0] val;
    int           cap;
    int           el;
    int           acc;
    grp = '0;
    for (int i = 0; i < N; i++) begin
      grp = grp | Bxs[i*W +: W];
    end
    cap  = (int'(prec_cap) > W) ? W : int'(prec_cap);
    acc  = 0;
    el   = 0;
    val  = '0;
    ell  = '0;
    offs = '0;
    for (int i = 0; i < N; i++) begin
      val = (CORR != 0) ? grp : Bxs[i*W +: W];
      if (val == '0) begin
        el = 0;
      end else begin
        el = W - trailing_zeros(32'(val), W);
        el = (el < cap) ? el : cap;
      end
      ell[i*EW +: EW]  = EW'(el);
      offs[i*PW +: PW] = (CORR != 0) ? '0 : PW'(acc);
      acc = acc + el;
    end
    e = (CORR != 0) ? PW'(el + NC) : PW'(acc + NC);
  end

endmodule

// File: rtl/pret_stream.sv
// PRET job engine: accepts a binary job, drives bit-plane-counter streams for the
// minimum needed length, counts the kernel output and holds the normalised result.
module pret_stream import pret_pkg::*; #(
  parameter int  W    = 8,
  parameter int  N    = 2,
  parameter int  NC   = 1,
  parameter int  CORR = 1,
  localparam int TW   = calc_tw(W, N, NC, CORR),
  localparam int EW   = calc_ew(W),
  localparam int LW   = calc_lw(TW)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] Bxs,
  input  logic [EW-1:0]  prec_cap,
  input  logic           abort,
  output logic           x_valid,
  output logic [N-1:0]   Xs,
  output logic [NC-1:0]  Xcs,
  input  logic           Z,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [TW-1:0]  Bz,
  output logic [LW-1:0]  out_len
);

  localparam int PW = calc_ew(TW);

  state_t          state_r, state_nx_s;
  logic [TW-1:0]   cnt_r;
  logic [LW-1:0]   ones_r, len_r, olen_r, ones_fin_s;
  logic [TW-1:0]   bz_r, bz_nx_s;
  logic [N*W-1:0]  v_r, v_s;
  logic [N*EW-1:0] ell_r, ell_s;
  logic [N*PW-1:0] off_r, off_s;
  logic [PW-1:0]   e_r, e_s;
  logic            last_s;

  pret_prec #(
    .W(W), .N(N), .NC(NC), .CORR(CORR), .EW(EW), .PW(PW)
  ) u_prec (
    .Bxs      (Bxs),
    .prec_cap (prec_cap),
    .ell      (ell_s),
    .offs     (off_s),
    .e        (e_s)
  );

  assign in_ready  = (state_r == ST_IDLE);
  assign x_valid   = (state_r == ST_RUN);
  assign out_valid = (state_r == ST_OUT);
  assign Bz        = bz_r;
  assign out_len   = olen_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state; abort wins over stream completion and over the output handshake.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
        end else if (last_s) begin
          state_nx_s = ST_OUT;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_OUT: begin
        if (abort || out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_OUT;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Operand values truncated to their group precision.
  always_comb begin
    v_s = '0;
    for (int i = 0; i < N; i++) begin
      v_s[i*W +: W] = Bxs[i*W +: W] >> (W - int'(ell_s[i*EW +: EW]));
    end
  end

  // Stream bits: operand compares against its bit-reversed counter slice, constants tap the top bits.
  always_comb begin
    Xs  = '0;
    Xcs = '0;
    if (state_r == ST_RUN) begin
      for (int i = 0; i < N; i++) begin
        Xs[i] = 32'(v_r[i*W +: W]) >
                bitrev((32'(cnt_r) >> off_r[i*PW +: PW]) &
                       ((32'd1 << ell_r[i*EW +: EW]) - 32'd1),
                       int'(ell_r[i*EW +: EW]));
      end
      for (int k = 0; k < NC; k++) begin
        Xcs[k] = |(cnt_r & (TW'(1) << (int'(e_r) - NC + k)));
      end
    end else begin
      Xs  = '0;
      Xcs = '0;
    end
  end

  // Final-cycle detect and normaliser; an all-ones stream saturates instead of wrapping.
  always_comb begin
    last_s     = ({1'b0, cnt_r} == (len_r - LW'(1)));
    ones_fin_s = ones_r + LW'(Z);
    if (ones_fin_s == len_r) begin
      bz_nx_s = '1;
    end else begin
      bz_nx_s = TW'(ones_fin_s << (TW - int'(e_r)));
    end
  end

  // Job registers, stream counter, ones counter and the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= '0;
      ones_r <= '0;
      len_r  <= '0;
      olen_r <= '0;
      bz_r   <= '0;
      v_r    <= '0;
      ell_r  <= '0;
      off_r  <= '0;
      e_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            v_r    <= v_s;
            ell_r  <= ell_s;
            off_r  <= off_s;
            e_r    <= e_s;
            len_r  <= LW'(1) << e_s;
            cnt_r  <= '0;
            ones_r <= '0;
          end
        end
        ST_RUN: begin
          cnt_r  <= cnt_r + TW'(1);
          ones_r <= ones_fin_s;
          if (last_s && !abort) begin
            bz_r   <= bz_nx_s;
            olen_r <= len_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pret_stream.sv
// Bench for pret_stream: a correlated and an uncorrelated instance (W=4, N=2, NC=1)
// run the same jobs against table vectors, hand sequences and a counting model.
module tb_pret_stream;

  logic       clk = 1'b0;
  logic       rst, in_valid, abort, out_ready;
  logic [7:0] bxs;
  logic [2:0] cap;
  int         kmode;

  logic       ir_c, xv_c, ov_c, z_c;
  logic [1:0] xs_c;
  logic [0:0] xcs_c;
  logic [4:0] bz_c;
  logic [5:0] len_c;

  logic       ir_u, xv_u, ov_u, z_u;
  logic [1:0] xs_u;
  logic [0:0] xcs_u;
  logic [8:0] bz_u;
  logic [9:0] len_u;

  int nchk = 0;
  int nerr = 0;
  int nx_c, nx_u, nov_c, nov_u;
  bit xs0_q[$];

  typedef struct {
    int b0, b1, cap, km, hold, lc, bc, lu, bu;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  // Kernel: 0 = AND of operands, 1 = constant one, 2 = operand 0, 3 = constant stream
  assign z_c = (kmode == 0) ? (xs_c[0] & xs_c[1]) : (kmode == 1) ? 1'b1 :
               (kmode == 2) ? xs_c[0] : xcs_c[0];
  assign z_u = (kmode == 0) ? (xs_u[0] & xs_u[1]) : (kmode == 1) ? 1'b1 :
               (kmode == 2) ? xs_u[0] : xcs_u[0];

  pret_stream #(.W(4), .N(2), .NC(1), .CORR(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c), .Bxs(bxs),
    .prec_cap(cap), .abort(abort), .x_valid(xv_c), .Xs(xs_c), .Xcs(xcs_c),
    .Z(z_c), .out_valid(ov_c), .out_ready(out_ready), .Bz(bz_c), .out_len(len_c)
  );

  pret_stream #(.W(4), .N(2), .NC(1), .CORR(0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_u), .Bxs(bxs),
    .prec_cap(cap), .abort(abort), .x_valid(xv_u), .Xs(xs_u), .Xcs(xcs_u),
    .Z(z_u), .out_valid(ov_u), .out_ready(out_ready), .Bz(bz_u), .out_len(len_u)
  );

  always @(negedge clk) begin
    if (xv_c) begin
      nx_c++;
      xs0_q.push_back(xs_c[0]);
    end
    if (xv_u) nx_u++;
    if (ov_c) nov_c++;
    if (ov_u) nov_u++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".in_ready_c"}, ir_c, 1);
    chk({tag, ".x_valid_c"}, xv_c, 0);
    chk({tag, ".Xs_c"}, xs_c, 0);
    chk({tag, ".Xcs_c"}, xcs_c, 0);
    chk({tag, ".out_valid_c"}, ov_c, 0);
    chk({tag, ".Bz_c"}, bz_c, 0);
    chk({tag, ".out_len_c"}, len_c, 0);
    chk({tag, ".in_ready_u"}, ir_u, 1);
    chk({tag, ".x_valid_u"}, xv_u, 0);
    chk({tag, ".Xs_u"}, xs_u, 0);
    chk({tag, ".Xcs_u"}, xcs_u, 0);
    chk({tag, ".out_valid_u"}, ov_u, 0);
    chk({tag, ".Bz_u"}, bz_u, 0);
    chk({tag, ".out_len_u"}, len_u, 0);
  endtask

  function automatic int tzc(input int x);
    int t = 0;
    int y = x;
    if (y == 0) return 4;
    while (y % 2 == 0) begin
      y = y / 2;
      t++;
    end
    return t;
  endfunction

  function automatic int precof(input int x, input int cp);
    int c = (cp > 4) ? 4 : cp;
    int need = 4 - tzc(x);
    if (x == 0) return 0;
    return (need < c) ? need : c;
  endfunction

  // Expected length and result from counting argument: bit-reversal is a permutation,
  // so an operand stream over its own slice holds exactly v ones per 2^ell cycles.
  task automatic model(input int b0, input int b1, input int cp, input int km, input int corr,
                       output int len, output int bz);
    int l0, l1, v0, v1, e, ones, tw;
    if (corr != 0) begin
      l0 = precof(b0 | b1, cp);
      l1 = l0;
      e  = l0 + 1;
    end else begin
      l0 = precof(b0, cp);
      l1 = precof(b1, cp);
      e  = l0 + l1 + 1;
    end
    v0  = b0 / (1 << (4 - l0));
    v1  = b1 / (1 << (4 - l1));
    len = 1 << e;
    tw  = (corr != 0) ? 5 : 9;
    case (km)
      0: ones = (corr != 0) ? ((v0 < v1) ? v0 : v1) * 2 : v0 * v1 * 2;
      1: ones = len;
      2: ones = v0 * (1 << (e - l0));
      default: ones = len / 2;
    endcase
    bz = (ones == len) ? (1 << tw) - 1 : ones * (1 << (tw - e));
  endtask

  task automatic run_job(input int b0, input int b1, input int cp, input int km, input int hold,
                         input int lc, input int bc, input int lu, input int bu);
    int fc, fu, cyc;
    kmode = km;
    bxs   = {4'(b1), 4'(b0)};
    cap   = 3'(cp);
    nx_c  = 0;
    nx_u  = 0;
    xs0_q.delete();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("accept.x_valid_c", xv_c, 1);
    chk("accept.in_ready_c", ir_c, 0);
    chk("accept.x_valid_u", xv_u, 1);
    chk("accept.in_ready_u", ir_u, 0);
    fc  = -1;
    fu  = -1;
    cyc = 1;
    while ((fc < 0 || fu < 0) && cyc < 1100) begin
      @(posedge clk); #1;
      cyc++;
      if (ov_c && fc < 0) fc = cyc;
      if (ov_u && fu < 0) fu = cyc;
    end
    chk("first_out_valid_cycle_c", fc, lc + 1);
    chk("first_out_valid_cycle_u", fu, lu + 1);
    chk("x_valid_cycles_c", nx_c, lc);
    chk("x_valid_cycles_u", nx_u, lu);
    chk("Bz_c", bz_c, bc);
    chk("out_len_c", len_c, lc);
    chk("Bz_u", bz_u, bu);
    chk("out_len_u", len_u, lu);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold.Bz_c", bz_c, bc);
      chk("hold.out_len_c", len_c, lc);
      chk("hold.out_valid_c", ov_c, 1);
      chk("hold.in_ready_c", ir_c, 0);
      chk("hold.Bz_u", bz_u, bu);
      chk("hold.in_ready_u", ir_u, 0);
    end
    if (fc < 0 || fu < 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("handshake.in_ready_c", ir_c, 1);
    chk("handshake.in_ready_u", ir_u, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    bxs = 8'd0; cap = 3'd4; kmode = 0;
    nx_c = 0; nx_u = 0; nov_c = 0; nov_u = 0;

    tbl[0] = '{8, 4, 4, 0, 5, 8, 8, 16, 64};
    tbl[1] = '{11, 0, 2, 2, 0, 8, 16, 8, 256};
    tbl[2] = '{0, 0, 4, 1, 0, 2, 31, 2, 511};
    tbl[3] = '{3, 5, 7, 0, 1, 32, 6, 512, 30};
    tbl[4] = '{8, 8, 4, 1, 0, 4, 31, 8, 511};
    tbl[5] = '{12, 2, 3, 2, 2, 16, 24, 64, 384};
    tbl[6] = '{5, 9, 4, 3, 0, 32, 16, 512, 256};

    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rst = 1'b0;

    for (int t = 0; t < 7; t++) begin
      run_job(tbl[t].b0, tbl[t].b1, tbl[t].cap, tbl[t].km, tbl[t].hold,
              tbl[t].lc, tbl[t].bc, tbl[t].lu, tbl[t].bu);
    end

    // Capped operand 1011 at precision 2: v0=2, stream 1,0,1,0 repeating
    run_job(11, 0, 2, 2, 0, 8, 16, 8, 256);
    chk("xs0_seq.len", xs0_q.size(), 8);
    for (int i = 0; i < xs0_q.size(); i++) begin
      chk("xs0_seq.bit", xs0_q[i], (i % 2 == 0) ? 1 : 0);
    end

    // Abort during RUN cycle 3
    kmode = 0; bxs = {4'd4, 4'd8}; cap = 3'd4;
    nov_c = 0; nov_u = 0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort.in_ready_c", ir_c, 1);
    chk("abort.x_valid_c", xv_c, 0);
    chk("abort.in_ready_u", ir_u, 1);
    chk("abort.x_valid_u", xv_u, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort.out_valid_cycles_c", nov_c, 0);
    chk("abort.out_valid_cycles_u", nov_u, 0);
    run_job(tbl[0].b0, tbl[0].b1, tbl[0].cap, tbl[0].km, 0,
            tbl[0].lc, tbl[0].bc, tbl[0].lu, tbl[0].bu);

    // Reset in the middle of RUN
    kmode = 1; bxs = {4'd5, 4'd3}; cap = 3'd4;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset("rst_run");
    rst = 1'b0;
    run_job(tbl[5].b0, tbl[5].b1, tbl[5].cap, tbl[5].km, 0,
            tbl[5].lc, tbl[5].bc, tbl[5].lu, tbl[5].bu);

    for (int j = 0; j < 16; j++) begin
      int rb0, rb1, rcp, rkm, elc, ebc, elu, ebu;
      rb0 = int'($urandom_range(0, 15));
      rb1 = int'($urandom_range(0, 15));
      rcp = int'($urandom_range(1, 7));
      rkm = int'($urandom_range(0, 3));
      model(rb0, rb1, rcp, rkm, 1, elc, ebc);
      model(rb0, rb1, rcp, rkm, 0, elu, ebu);
      run_job(rb0, rb1, rcp, rkm, j % 3, elc, ebc, elu, ebu);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
